// File: rtl/l4_parse_sequencer_pkg.sv
// Shared types and constants for the L2-L4 header parse sequencer.
// Holds the FSM state, packet class encoding and protocol constants.
package l4_parse_sequencer_pkg;

  typedef enum logic {
    S_HDR,
    S_DESC
  } seq_state_t;

  typedef enum logic [1:0] {
    CLS_OTHER     = 2'b00,
    CLS_UDP       = 2'b01,
    CLS_TCP       = 2'b10,
    CLS_MALFORMED = 2'b11
  } pkt_class_t;

  localparam int unsigned ETH_HDR_LEN    = 14;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPPROTO_TCP    = 8'd6;
  localparam logic [7:0]  IPPROTO_UDP    = 8'd17;

  function automatic logic is_l4(input logic [7:0] p);
    return (p == IPPROTO_TCP) || (p == IPPROTO_UDP);
  endfunction

endpackage

// File: rtl/l4_parse_sequencer_keep_popcount.sv
// Counts asserted byte enables of one stream beat.
// Output is wide enough to hold a full beat (BYTES).
module l4_parse_sequencer_keep_popcount #(
  parameter int BYTES = 8,
  parameter int CW    = $clog2(BYTES) + 1
) (
  input  logic [BYTES-1:0] keep_i,
  output logic [CW-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < BYTES; i++) begin
      count_o = count_o + CW'(keep_i[i]);
    end
  end

endmodule

// File: rtl/l4_parse_sequencer.sv
// Per-packet sequencer for the eth/ipv4/l4 parser chain.
// Gates parser stages per beat, classifies, emits one descriptor.
module l4_parse_sequencer
  import l4_parse_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LEN_W      = 16,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int IDXW      = $clog2(BYTES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_tvalid,
  input  logic             s_tlast,
  input  logic [BYTES-1:0] s_tkeep,
  output logic             s_tready,
  input  logic [15:0]      ethertype,
  input  logic             eth_done,
  input  logic             ipv4_hdr_valid,
  input  logic [3:0]       ipv4_ihl,
  input  logic [7:0]       ipv4_protocol,
  input  logic             l4_done,
  output logic             beat_valid,
  output logic             eth_en,
  output logic             ipv4_en,
  output logic [IDXW-1:0]  ipv4_start_idx,
  output logic             l4_en,
  output logic [IDXW-1:0]  l4_start_idx,
  output logic             parser_clear,
  output logic             desc_valid,
  input  logic             desc_ready,
  output logic [1:0]       desc_class,
  output logic [LEN_W-1:0] desc_len,
  output logic [LEN_W-1:0] drop_cnt
);

  localparam logic [LEN_W:0] ETH_END = (LEN_W+1)'(ETH_HDR_LEN);

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] drop_q, drop_d;
  pkt_class_t       class_q, class_d, cls_w;

  logic [IDXW:0]    keep_cnt;
  logic [LEN_W:0]   cnt_ext, beat_end, l4off;
  logic [LEN_W-1:0] cnt_sat;
  logic             is_v4, l4_ok;

  l4_parse_sequencer_keep_popcount #(
    .BYTES (BYTES)
  ) u_pop (
    .keep_i  (s_tkeep),
    .count_o (keep_cnt)
  );

  assign cnt_ext  = {1'b0, byte_cnt_q};
  assign beat_end = cnt_ext + (LEN_W+1)'(keep_cnt);
  assign cnt_sat  = beat_end[LEN_W] ? '1 : beat_end[LEN_W-1:0];
  assign l4off    = ETH_END + (LEN_W+1)'({ipv4_ihl, 2'b00});

  assign is_v4 = eth_done && (ethertype == ETHERTYPE_IPV4);
  assign l4_ok = is_v4 && ipv4_hdr_valid && is_l4(ipv4_protocol)
              && (ipv4_ihl >= 4'd5);

  assign beat_valid = s_tvalid && s_tready;
  assign eth_en     = beat_valid && (cnt_ext < ETH_END);
  // IHL unknown until ipv4_hdr_valid: keep the header window open
  assign ipv4_en    = beat_valid && is_v4 && (beat_end > ETH_END)
                   && (!ipv4_hdr_valid || (cnt_ext < l4off));
  assign l4_en      = beat_valid && l4_ok && (beat_end > l4off)
                   && !l4_done;

  assign ipv4_start_idx = (ipv4_en && (cnt_ext <= ETH_END))
                        ? IDXW'(ETH_HDR_LEN % BYTES) : '0;
  assign l4_start_idx   = (l4_en && (cnt_ext <= l4off))
                        ? l4off[IDXW-1:0] : '0;

  always_comb begin
    cls_w = CLS_MALFORMED;
    if (!eth_done) begin
      cls_w = CLS_MALFORMED;
    end else if (ethertype != ETHERTYPE_IPV4) begin
      cls_w = CLS_OTHER;
    end else if (!ipv4_hdr_valid || (ipv4_ihl < 4'd5)
                 || (beat_end < l4off)) begin
      cls_w = CLS_MALFORMED;
    end else if (!is_l4(ipv4_protocol)) begin
      cls_w = CLS_OTHER;
    end else if (!l4_done) begin
      cls_w = CLS_MALFORMED;
    end else if (ipv4_protocol == IPPROTO_UDP) begin
      cls_w = CLS_UDP;
    end else begin
      cls_w = CLS_TCP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR:  if (beat_valid && s_tlast) state_d = S_DESC;
      S_DESC: if (desc_ready) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  always_comb begin
    s_tready     = (state_q == S_HDR);
    desc_valid   = (state_q == S_DESC);
    parser_clear = (state_q == S_DESC) && desc_ready;
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    class_d    = class_q;
    drop_d     = drop_q;
    if (parser_clear) begin
      byte_cnt_d = '0;
    end else if (beat_valid) begin
      byte_cnt_d = cnt_sat;
    end
    if (beat_valid && s_tlast) begin
      len_d   = cnt_sat;
      class_d = cls_w;
    end
    if (parser_clear && (class_q == CLS_MALFORMED) && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      len_q      <= '0;
      class_q    <= CLS_OTHER;
      drop_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      class_q    <= class_d;
      drop_q     <= drop_d;
    end
  end

  assign desc_class = class_q;
  assign desc_len   = len_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_l4_parse_sequencer.sv
// Scoreboard bench for l4_parse_sequencer with a byte-range packet model.
// Driver pushes expected beats/descriptors; a negedge monitor checks them.
module tb_l4_parse_sequencer;

  localparam int LW = 16;
  localparam int NB = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic [NB-1:0] s_tkeep = '0;
  logic          s_tready;
  logic [15:0]   ethertype = '0;
  logic          eth_done = 1'b0;
  logic          ipv4_hdr_valid = 1'b0;
  logic [3:0]    ipv4_ihl = '0;
  logic [7:0]    ipv4_protocol = '0;
  logic          l4_done = 1'b0;
  logic          beat_valid, eth_en, ipv4_en, l4_en;
  logic [IW-1:0] ipv4_start_idx, l4_start_idx;
  logic          parser_clear, desc_valid;
  logic          desc_ready = 1'b0;
  logic [1:0]    desc_class;
  logic [LW-1:0] desc_len, drop_cnt;

  l4_parse_sequencer #(.DATA_WIDTH(64), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tkeep(s_tkeep),
    .s_tready(s_tready),
    .ethertype(ethertype), .eth_done(eth_done),
    .ipv4_hdr_valid(ipv4_hdr_valid), .ipv4_ihl(ipv4_ihl),
    .ipv4_protocol(ipv4_protocol), .l4_done(l4_done),
    .beat_valid(beat_valid), .eth_en(eth_en),
    .ipv4_en(ipv4_en), .ipv4_start_idx(ipv4_start_idx),
    .l4_en(l4_en), .l4_start_idx(l4_start_idx),
    .parser_clear(parser_clear), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .desc_class(desc_class),
    .desc_len(desc_len), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit eth; bit ip; int ipi; bit l4; int l4i;
  } beat_exp_t;
  typedef struct {
    int cls; int len;
  } desc_exp_t;

  beat_exp_t bq[$];
  desc_exp_t dq[$];
  int errors = 0;
  int checks = 0;
  int exp_drop = 0;
  int hold_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int l4len(input int pr);
    return (pr == 17) ? 8 : 20;
  endfunction

  function automatic bit is_l4p(input int pr);
    return (pr == 6) || (pr == 17);
  endfunction

  // Class from the packet's byte layout and its total length
  function automatic int exp_class(input int len, input int et,
                                   input int ihl, input int pr);
    int hdr_end;
    hdr_end = 14 + 4 * ihl;
    if (len < 14) return 3;
    if (et != 16'h0800) return 0;
    if (len < 24 || ihl < 5 || len < hdr_end) return 3;
    if (!is_l4p(pr)) return 0;
    if (len < hdr_end + l4len(pr)) return 3;
    return (pr == 17) ? 1 : 2;
  endfunction

  // Parser stage model: each done level rises on the beat completing its bytes
  task automatic set_levels(input int e, input int et,
                            input int ihl, input int pr);
    bit hv;
    eth_done = (e >= 14);
    ethertype = eth_done ? 16'(et) : 16'h0;
    hv = eth_done && (et == 16'h0800) && (e >= 24);
    ipv4_hdr_valid = hv;
    ipv4_ihl = hv ? 4'(ihl) : 4'h0;
    ipv4_protocol = hv ? 8'(pr) : 8'h0;
    l4_done = hv && is_l4p(pr) && (ihl >= 5)
           && (e >= 14 + 4 * ihl + l4len(pr));
  endtask

  function automatic beat_exp_t exp_beat(input int o, input int e,
                                         input int et, input int ihl,
                                         input int pr);
    beat_exp_t b;
    bit v4;
    int off;
    v4 = (e >= 14) && (et == 16'h0800);
    off = 14 + 4 * ihl;
    b.eth = (o < 14);
    b.ip = v4 && (e > 14) && ((e < 24) || (o < off));
    b.ipi = (b.ip && o <= 14) ? 6 : 0;
    b.l4 = v4 && (e >= 24) && is_l4p(pr) && (ihl >= 5)
        && (e > off) && (e < off + l4len(pr));
    b.l4i = (b.l4 && o <= off) ? (off % 8) : 0;
    return b;
  endfunction

  task automatic wait_accept();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      k++;
      if (k > 100) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got tready=0, expected 1");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input int len, input int et, input int ihl,
                          input int pr, input int hold, input int max_beats);
    int o, n, e, nb;
    desc_exp_t d;
    o = 0; nb = 0;
    while (o < len && nb < max_beats) begin
      n = (len - o < NB) ? (len - o) : NB;
      e = o + n;
      if ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      set_levels(e, et, ihl, pr);
      bq.push_back(exp_beat(o, e, et, ihl, pr));
      if (e == len) begin
        d.cls = exp_class(len, et, ihl, pr);
        d.len = len;
        dq.push_back(d);
      end
      s_tvalid = 1'b1;
      s_tkeep = NB'((1 << n) - 1);
      s_tlast = (e == len);
      wait_accept();
      o = e; nb++;
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    if (hold > 0) hold_cnt = hold;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tready"}, s_tready, 1);
    chk({tag, "_dvalid"}, desc_valid, 0);
    chk({tag, "_clear"}, parser_clear, 0);
    chk({tag, "_class"}, desc_class, 0);
    chk({tag, "_len"}, desc_len, 0);
    chk({tag, "_drop"}, drop_cnt, 0);
    chk({tag, "_ens"}, {29'd0, eth_en, ipv4_en, l4_en}, 0);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((dq.size() != 0 || bq.size() != 0) && k < 300) begin
      @(posedge clk); k++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk); #2;
      if (hold_cnt > 0) begin
        desc_ready = 1'b0;
        hold_cnt--;
      end else begin
        desc_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  always @(negedge clk) begin
    beat_exp_t b;
    desc_exp_t d;
    if (!rst_n) begin
      exp_drop = 0;
    end else begin
      if (beat_valid) begin
        if (bq.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          b = bq.pop_front();
          chk("eth_en", eth_en, b.eth);
          chk("ipv4_en", ipv4_en, b.ip);
          chk("ipv4_idx", ipv4_start_idx, b.ipi);
          chk("l4_en", l4_en, b.l4);
          chk("l4_idx", l4_start_idx, b.l4i);
        end
      end else begin
        chk("idle_ens", {29'd0, eth_en, ipv4_en, l4_en}, 0);
      end
      if (desc_valid) begin
        chk("busy_tready", s_tready, 0);
        if (dq.size() == 0) begin
          chk("desc_unexpected", 1, 0);
        end else begin
          d = dq[0];
          chk("desc_class", desc_class, d.cls);
          chk("desc_len", desc_len, d.len);
          chk("drop_cnt", drop_cnt, exp_drop);
          if (desc_ready) begin
            chk("clear_pulse", parser_clear, 1);
            void'(dq.pop_front());
            if (d.cls == 3) exp_drop++;
          end else begin
            chk("clear_hold", parser_clear, 0);
          end
        end
      end else begin
        chk("clear_idle", parser_clear, 0);
      end
    end
  end

  initial begin
    int r, et, ihl, pr;
    #1;
    check_reset_vals("rst0");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_pkt(60, 16'h0800, 5, 17, 0, 99);
    send_pkt(74, 16'h0800, 6, 6, 0, 99);
    send_pkt(42, 16'h0806, 5, 0, 0, 99);
    send_pkt(30, 16'h0800, 5, 6, 0, 99);
    send_pkt(8, 16'h0800, 5, 17, 0, 99);
    send_pkt(60, 16'h0800, 3, 17, 0, 99);
    send_pkt(50, 16'h0800, 5, 1, 0, 99);
    send_pkt(20, 16'h0800, 5, 17, 0, 99);
    send_pkt(41, 16'h0800, 5, 17, 0, 99);
    send_pkt(42, 16'h0800, 5, 17, 6, 99);
    send_pkt(66, 16'h0800, 7, 6, 0, 99);
    wait_drain();
    send_pkt(60, 16'h0800, 5, 17, 0, 2);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    chk("rst_mid_bv", beat_valid, 0);
    set_levels(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_pkt(74, 16'h0800, 6, 6, 0, 99);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      et = (r != 0) ? 16'h0800 : 16'h0806;
      ihl = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(5, 7);
      r = $urandom_range(0, 2);
      pr = (r == 0) ? 17 : ((r == 1) ? 6 : 1);
      send_pkt($urandom_range(1, 110), et, ihl, pr,
               ($urandom_range(0, 7) == 0) ? 4 : 0, 99);
    end
    wait_drain();
    chk("desc_drained", dq.size(), 0);
    chk("beats_drained", bq.size(), 0);
    chk("final_drop", drop_cnt, exp_drop);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
